// File: rtl/mdu_pkg.sv
// Shared types and encodings for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  // Decoder qualifies start with this funct7 on R-type instructions.
  localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iteration datapath: one shift-add multiply bit or one restoring-divide bit per step.
// {o_hi,o_lo} is the product after XLEN multiply steps; o_lo/o_hi are quotient/remainder after XLEN divide steps.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic            r_div;

  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  assign w_add   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
  // Partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits
  // and any successful subtraction fits back into XLEN bits.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[XLEN-1:0] - r_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_div <= i_div;
    end else if (i_step) begin
      if (r_div) begin
        r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_add[XLEN:1];
        r_lo <= {w_add[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: FSM, operand sign handling, special cases and result fix-up.
// Define MDU_EARLY_OUT_EN to fast-path zero multiplies and divides with |dividend| < |divisor|.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t       r_state;
  mdu_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic             r_neg;
  logic [XLEN-1:0]  r_result;

  logic              w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_neg, w_fast;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_fast_res, w_fix_res, w_hi, w_lo, w_q, w_r;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept   = start & ~flush & ((r_state == IDLE) | (r_state == DONE));
  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == MDU_MULH) | (funct3 == MDU_MULHSU) |
                      (funct3 == MDU_DIV)  | (funct3 == MDU_REM);
  assign w_b_signed = (funct3 == MDU_MULH) | (funct3 == MDU_DIV) | (funct3 == MDU_REM);
  assign w_sa       = w_a_signed & op_a[XLEN-1];
  assign w_sb       = w_b_signed & op_b[XLEN-1];
  assign w_abs_a    = w_sa ? -op_a : op_a;
  assign w_abs_b    = w_sb ? -op_b : op_b;
  // Remainder follows the dividend; products and quotients follow sign(a)^sign(b).
  assign w_neg      = (funct3 == MDU_REM) ? w_sa : (w_sa ^ w_sb);

  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = '0;
    if (w_is_div && (op_b == '0)) begin
      w_fast     = 1'b1;
      w_fast_res = funct3[1] ? op_a : {XLEN{1'b1}};
    end else if (w_is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (op_b == {XLEN{1'b1}})) begin
      w_fast     = 1'b1;
      w_fast_res = funct3[1] ? {XLEN{1'b0}} : op_a;
    end
`ifdef MDU_EARLY_OUT_EN
    else if (!w_is_div && ((op_a == '0) || (op_b == '0))) begin
      w_fast     = 1'b1;
      w_fast_res = '0;
    end else if (w_is_div && (w_abs_a < w_abs_b)) begin
      w_fast     = 1'b1;
      w_fast_res = funct3[1] ? op_a : {XLEN{1'b0}};
    end
`endif
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept & ~w_fast),
    .i_step (r_state == RUN),
    .i_div  (w_is_div),
    .i_a    (w_abs_a),
    .i_b    (w_abs_b),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  assign w_prod = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
  assign w_q    = r_neg ? -w_lo : w_lo;
  assign w_r    = r_neg ? -w_hi : w_hi;

  always_comb begin
    w_fix_res = '0;
    if (r_funct3[2]) begin
      w_fix_res = r_funct3[1] ? w_r : w_q;
    end else if (r_funct3 == MDU_MUL) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_fast ? DONE : RUN;
      RUN: begin
        if (flush) w_next = IDLE;
        else if (r_cnt == CNT_W'(1)) w_next = FIX;
      end
      FIX:  w_next = flush ? IDLE : DONE;
      DONE: begin
        if (w_accept) w_next = w_fast ? DONE : RUN;
        else          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_funct3 <= funct3;
        r_neg    <= w_neg;
        r_cnt    <= CNT_W'(XLEN);
        if (w_fast) r_result <= w_fast_res;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if ((r_state == FIX) && !flush) r_result <= w_fix_res;
    end
  end

  assign stall  = (start & (r_state == IDLE)) | (r_state == RUN) | (r_state == FIX);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table plus flush, back-to-back and reset sequences.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int LAT = 34;
`ifdef MDU_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = LAT;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] result;

  mdu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] exp;
    int          t0;
    int          lat;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  vec_t vecs[18];
  logic [31:0] last_res;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Scoreboard: every done pops one expected result and its required latency.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.nm, "_result"}, result, e.exp);
        check({e.nm, "_latency"}, 32'(cyc_cnt - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    sb.push_back('{nm, exp, cyc_cnt, lat});
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check({nm, "_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    bit bad;
    int k;
    issue(nm, f3, a, b, exp, lat);
    @(negedge clk);
    bad = (stall !== 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (k < 100) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (stall !== 1'b1) bad = 1'b1;
      k++;
    end
    if (k >= 100) begin
      check({nm, "_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end else begin
      check({nm, "_stall_busy"}, {31'd0, bad}, 32'd0);
      check({nm, "_stall_done"}, {31'd0, stall}, 32'd0);
    end
    last_res = exp;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT};
    vecs[1]  = '{MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT};
    vecs[2]  = '{MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT};
    vecs[3]  = '{MDU_DIV,    32'd100,      32'd0,        32'hFFFFFFFF, 1};
    vecs[4]  = '{MDU_REMU,   32'd100,      32'd0,        32'd100,      1};
    vecs[5]  = '{MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[6]  = '{MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT};
    vecs[7]  = '{MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[8]  = '{MDU_DIVU,   32'd100,      32'd7,        32'd14,       LAT};
    vecs[9]  = '{MDU_DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, LAT};
    vecs[10] = '{MDU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT};
    vecs[11] = '{MDU_MULHU,  32'hFFFFFFFF, 32'd2,        32'd1,        LAT};
    vecs[12] = '{MDU_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LAT};
    vecs[13] = '{MDU_REMU,   32'd100,      32'd7,        32'd2,        LAT};
    vecs[14] = '{MDU_MUL,    32'd0,        32'd5,        32'd0,        EL};
    vecs[15] = '{MDU_DIVU,   32'd3,        32'd9,        32'd0,        EL};
    vecs[16] = '{MDU_REM,    32'hFFFFFFFD, 32'd9,        32'hFFFFFFFD, EL};
    vecs[17] = '{MDU_MULHU,  32'h00001234, 32'd0,        32'd0,        EL};

    repeat (2) @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Flush a DIVU during its tenth cycle; the restart at cycle 12 must run to completion.
    @(posedge clk); #1;
    start = 1'b1; funct3 = MDU_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_result_held", result, last_res);
    run_op("after_flush", MDU_DIVU, 32'd1000, 32'd3, 32'd333, LAT);

    // start qualified by flush in IDLE must not be accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = MDU_DIV; op_a = 32'd5; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_stall", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_start_result", result, last_res);

    // Back-to-back: second start lands in the DONE cycle; a start mid-RUN is ignored.
    issue("b2b_first", MDU_MUL, 32'd6, 32'd7, 32'd42, LAT);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; funct3 = MDU_DIVU; op_a = 32'd9; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (27) @(posedge clk);
    issue("b2b_second", MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);
    @(posedge clk); #1;
    start = 1'b0;
    wait_empty("b2b", 80);

    // Asynchronous reset in the middle of RUN.
    issue("rst_mid", MDU_MUL, 32'd3, 32'd5, 32'd15, LAT);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_done_result", result, 32'd0);
    run_op("after_rst", MDU_MUL, 32'd3, 32'd5, 32'd15, LAT);
    wait_empty("final", 10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
